if_id_queue: RTL and testbench

Decoupling instruction queue between the fetch stage and the decode stage of the 32-bit in-order pipeline. It captures each fetched instruction with its PC and PC+4 into a small circular buffer and presents the oldest entry to decode. It raises a stall to fetch when full and discards all contents on a taken branch resolved in EX. It replaces the plain IF/ID pipeline register, so fetch keeps running while decode is held by a hazard.

---
 rtl/if_id_queue_pkg.sv | 19 +
 rtl/if_id_queue.sv | 94 +++++++++
 tb/tb_if_id_queue.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/if_id_queue_pkg.sv
// Shared fetch/decode definitions: queue depth default, NOP encoding, IF/ID packet.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package if_id_queue_pkg;

    // Default queue depth; must be a power of two and at least 2.
    localparam int IF_ID_QDEPTH = 4;

    // addi x0, x0, 0: what decode sees when the queue is empty.
    localparam logic [31:0] NOOP_INST = 32'h0000_0013;

    // One fetched instruction as handed from fetch to decode.
    typedef struct packed {
        logic [31:0] PC;
        logic [31:0] NPC;
        logic [31:0] IR;
    } if_id_packet_t;

endpackage

// File: rtl/if_id_queue.sv
// Circular instruction queue between fetch and decode; replaces the IF/ID register.
// Latency: an entry pushed at edge N is at the head outputs in cycle N+1; no input-to-output bypass.
// Backpressure: if_stall when full (registered, so a same-cycle pop does not free a slot); id_stall holds the head.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset of control state
//   if_*_in                  instruction presented by fetch (PC, PC+4, IR, valid)
//   ex_take_branch_out       taken branch resolved in EX: discard everything queued
//   id_stall                 decode cannot take the head entry this cycle
//   if_stall                 queue full; fetch holds and re-presents the same instruction
//   if_id_*_out              head entry, valid flag and occupancy
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH = IF_ID_QDEPTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [31:0]                    if_PC_in,
    input  logic [31:0]                    if_NPC_in,
    input  logic [31:0]                    if_IR_in,
    input  logic                           if_valid_inst_in,
    input  logic                           ex_take_branch_out,
    input  logic                           id_stall,
    output logic                           if_stall,
    output logic [31:0]                    if_id_PC_out,
    output logic [31:0]                    if_id_NPC_out,
    output logic [31:0]                    if_id_IR_out,
    output logic                           if_id_valid_inst_out,
    output logic [$clog2(DEPTH+1)-1:0]     if_id_count_out
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    if_id_packet_t mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic          push;
    logic          pop;
    logic          empty;
    if_id_packet_t head_pkt;
    if_id_packet_t in_pkt;

    assign empty    = (count == '0);
    assign if_stall = (count == CW'(DEPTH));

    // Full refuses a push even when the head pops this cycle, keeping if_stall
    // purely a function of the count register.
    assign push = if_valid_inst_in & ~if_stall & ~ex_take_branch_out;
    assign pop  = ~empty & ~id_stall & ~ex_take_branch_out;

    assign in_pkt = '{PC: if_PC_in, NPC: if_NPC_in, IR: if_IR_in};

    // Control state. Pointers are log2(DEPTH) bits, so they wrap on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (ex_take_branch_out) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage carries no reset; only slots between head and tail are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= in_pkt;
        end
    end

    assign head_pkt = mem[head];

    // PC/NPC show the stale head slot when empty; IR is forced to a NOP.
    assign if_id_PC_out         = head_pkt.PC;
    assign if_id_NPC_out        = head_pkt.NPC;
    assign if_id_IR_out         = empty ? NOOP_INST : head_pkt.IR;
    assign if_id_valid_inst_out = ~empty;
    assign if_id_count_out      = count;

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed scenarios plus random traffic against a queue model.
// Latency: outputs checked 1 time unit after each rising edge, against the model advanced at that edge.
// Backpressure: model refuses pushes when it holds DEPTH entries, regardless of a same-cycle pop.
module tb_if_id_queue;
    import if_id_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   if_PC_in;
    logic [31:0]   if_NPC_in;
    logic [31:0]   if_IR_in;
    logic          if_valid_inst_in;
    logic          ex_take_branch_out;
    logic          id_stall;
    logic          if_stall;
    logic [31:0]   if_id_PC_out;
    logic [31:0]   if_id_NPC_out;
    logic [31:0]   if_id_IR_out;
    logic          if_id_valid_inst_out;
    logic [CW-1:0] if_id_count_out;

    if_id_queue #(.DEPTH(DEPTH)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .if_PC_in             (if_PC_in),
        .if_NPC_in            (if_NPC_in),
        .if_IR_in             (if_IR_in),
        .if_valid_inst_in     (if_valid_inst_in),
        .ex_take_branch_out   (ex_take_branch_out),
        .id_stall             (id_stall),
        .if_stall             (if_stall),
        .if_id_PC_out         (if_id_PC_out),
        .if_id_NPC_out        (if_id_NPC_out),
        .if_id_IR_out         (if_id_IR_out),
        .if_id_valid_inst_out (if_id_valid_inst_out),
        .if_id_count_out      (if_id_count_out)
    );

    always #5 clk = ~clk;

    // Reference: the queue contents in order, oldest first.
    if_id_packet_t model_q[$];
    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        int sz;
        sz = model_q.size();
        check({tag, ".count"}, 32'(if_id_count_out), 32'(sz));
        check({tag, ".stall"}, 32'(if_stall), 32'(sz == DEPTH));
        check({tag, ".valid"}, 32'(if_id_valid_inst_out), 32'(sz != 0));
        if (sz != 0) begin
            check({tag, ".pc"},  if_id_PC_out,  model_q[0].PC);
            check({tag, ".npc"}, if_id_NPC_out, model_q[0].NPC);
            check({tag, ".ir"},  if_id_IR_out,  model_q[0].IR);
        end else begin
            check({tag, ".ir_nop"}, if_id_IR_out, NOOP_INST);
        end
    endtask

    // One clock: present inputs, advance the model at the edge, then compare.
    task automatic cycle(input string tag, input bit v, input logic [31:0] pc,
                         input bit ids, input bit br);
        if_packet_drive: begin
            if_valid_inst_in   = v;
            if_PC_in           = pc;
            if_NPC_in          = pc + 32'd4;
            if_IR_in           = $urandom;
            id_stall           = ids;
            ex_take_branch_out = br;
        end
        @(posedge clk);
        if (br) begin
            model_q.delete();
        end else begin
            bit was_full;
            was_full = (model_q.size() == DEPTH);
            if (!ids && model_q.size() != 0) begin
                void'(model_q.pop_front());
            end
            if (v && !was_full) begin
                model_q.push_back('{PC: pc, NPC: pc + 32'd4, IR: if_IR_in});
            end
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) begin
            cycle("drain", 1'b0, 32'h0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        rst                = 1'b1;
        if_valid_inst_in   = 1'b0;
        if_PC_in           = '0;
        if_NPC_in          = '0;
        if_IR_in           = '0;
        id_stall           = 1'b0;
        ex_take_branch_out = 1'b0;
        #12;
        check_outputs("reset");
        rst = 1'b0;

        // Streaming: one in, one out every cycle, occupancy stays at 1.
        cycle("stream0", 1'b1, 32'h0, 1'b0, 1'b0);
        cycle("stream4", 1'b1, 32'h4, 1'b0, 1'b0);
        cycle("stream8", 1'b1, 32'h8, 1'b0, 1'b0);
        drain();

        // Fill with decode held, a fifth instruction must be refused.
        for (int i = 0; i < DEPTH; i++) begin
            cycle("fill", 1'b1, 32'h10 + 32'(4 * i), 1'b1, 1'b0);
        end
        cycle("fill_refuse", 1'b1, 32'h20, 1'b1, 1'b0);
        cycle("fill_release", 1'b1, 32'h20, 1'b0, 1'b0);
        cycle("fill_accept", 1'b1, 32'h20, 1'b0, 1'b0);
        drain();

        // Full with a simultaneous pop: push refused this cycle, accepted next.
        for (int i = 0; i < DEPTH; i++) begin
            cycle("full_fill", 1'b1, 32'h60 + 32'(4 * i), 1'b1, 1'b0);
        end
        cycle("full_pop", 1'b1, 32'h50, 1'b0, 1'b0);
        cycle("full_retry", 1'b1, 32'h50, 1'b1, 1'b0);
        drain();

        // Flush with a push and a pop request in the same cycle.
        for (int i = 0; i < 3; i++) begin
            cycle("pre_flush", 1'b1, 32'h30 + 32'(4 * i), 1'b1, 1'b0);
        end
        cycle("flush", 1'b1, 32'h40, 1'b0, 1'b1);
        cycle("target", 1'b1, 32'h80, 1'b1, 1'b0);
        drain();

        // Random traffic across many pointer wraps, occasional flushes.
        for (int i = 0; i < 300; i++) begin
            cycle("rand",
                  ($urandom_range(0, 3) != 0),
                  ($urandom & 32'hFFFF_FFFC),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 24) == 0));
        end
        drain();

        // Asynchronous reset in the middle of a cycle with three entries queued.
        for (int i = 0; i < 3; i++) begin
            cycle("pre_arst", 1'b1, 32'hA0 + 32'(4 * i), 1'b1, 1'b0);
        end
        if_valid_inst_in = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_q.delete();
        check_outputs("async_rst");
        #2;
        rst = 1'b0;
        cycle("post_arst", 1'b1, 32'hC0, 1'b0, 1'b0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
